// File: rtl/eq_pkg.sv
// Shared audio-path types and I2S framing constants.
package eq_pkg;
  typedef logic signed [15:0] aud_smpl_t;

  localparam int I2S_SLOT_BITS = 24;
  localparam int I2S_SCLK_HALF = 16;
  localparam int I2S_BIT_CNT_W = $clog2(2 * I2S_SLOT_BITS);

  // Counter width needed to index every sclk period of a stereo frame.
  function automatic int bit_cnt_w(input int slot_bits);
    return $clog2(2 * slot_bits);
  endfunction
endpackage

// File: rtl/i2s_xmtr_if.sv
// Stereo sample handshake between the EQ output stage and the I2S transmitter.
interface i2s_xmtr_if #(
  parameter int DATA_W = 16
);
  logic signed [DATA_W-1:0] lft_smpl;
  logic signed [DATA_W-1:0] rght_smpl;
  logic                     smpl_vld;
  logic                     smpl_rdy;

  modport master (output lft_smpl, rght_smpl, smpl_vld, input smpl_rdy);
  modport slave  (input lft_smpl, rght_smpl, smpl_vld, output smpl_rdy);
endinterface

// File: rtl/i2s_sclk_gen.sv
// Bit-clock divider: registered I2S_sclk plus strobes marking the clk edge on
// which sclk is about to fall or rise.
module i2s_sclk_gen #(
  parameter int SCLK_HALF = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic I2S_sclk,
  output logic sclk_fall,
  output logic sclk_rise
);
  localparam int DIV_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_HALF - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             wrap;

  // Strobes are combinational so serial state updates on the same edge sclk moves.
  assign wrap      = (div_cnt == DIV_LAST);
  assign sclk_fall = wrap & I2S_sclk;
  assign sclk_rise = wrap & ~I2S_sclk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      I2S_sclk <= 1'b0;
    end else if (wrap) begin
      div_cnt  <= '0;
      I2S_sclk <= ~I2S_sclk;
    end else begin
      div_cnt  <= div_cnt + DIV_W'(1);
    end
  end
endmodule

// File: rtl/i2s_xmtr.sv
// I2S master transmitter: one-deep hold buffer feeding an MSB-first serializer
// that sends left then right in standard (one-bit-delayed) I2S slots.
module i2s_xmtr
  import eq_pkg::*;
#(
  parameter int SCLK_HALF = I2S_SCLK_HALF,
  parameter int SLOT_BITS = I2S_SLOT_BITS,
  parameter int DATA_W    = $bits(aud_smpl_t)
) (
  input  logic       clk,
  input  logic       rst_n,
  i2s_xmtr_if.slave  bus,
  output logic       I2S_sclk,
  output logic       I2S_ws,
  output logic       I2S_data,
  output logic       underrun
);
  localparam int CNT_W = bit_cnt_w(SLOT_BITS);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] K_LAST     = CNT_W'(2 * SLOT_BITS - 1);
  localparam logic [CNT_W-1:0] K_SLOT     = CNT_W'(SLOT_BITS);
  localparam logic [CNT_W-1:0] K_LFT_END  = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] K_RGHT_END = CNT_W'(SLOT_BITS + DATA_W);

  logic                     sclk_fall;
  logic                     sclk_rise;
  logic [CNT_W-1:0]         bit_cnt;
  logic [CNT_W-1:0]         k_next;
  logic [IDX_W-1:0]         lft_off;
  logic [IDX_W-1:0]         rght_off;
  logic signed [DATA_W-1:0] cur_lft;
  logic signed [DATA_W-1:0] cur_rght;
  logic signed [DATA_W-1:0] hold_lft;
  logic signed [DATA_W-1:0] hold_rght;
  logic                     hold_full;
  logic                     frame_wrap;
  logic                     data_next;
  logic                     accept;

  i2s_sclk_gen #(.SCLK_HALF(SCLK_HALF)) u_sclk_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .I2S_sclk  (I2S_sclk),
    .sclk_fall (sclk_fall),
    .sclk_rise (sclk_rise)
  );

  assign bus.smpl_rdy = ~hold_full;
  assign accept       = bus.smpl_vld & ~hold_full;

  // Bit k of the frame carries sample bit DATA_W-k, so the MSB lags the ws edge by one sclk.
  always_comb begin
    k_next     = (bit_cnt == K_LAST) ? '0 : bit_cnt + CNT_W'(1);
    frame_wrap = sclk_fall & (bit_cnt == K_LAST);
    lft_off    = IDX_W'(K_LFT_END - k_next);
    rght_off   = IDX_W'(K_RGHT_END - k_next);
    data_next  = 1'b0;
    if ((k_next >= CNT_W'(1)) && (k_next <= K_LFT_END))
      data_next = cur_lft[lft_off];
    else if ((k_next > K_SLOT) && (k_next <= K_RGHT_END))
      data_next = cur_rght[rght_off];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      I2S_ws    <= 1'b0;
      I2S_data  <= 1'b0;
      underrun  <= 1'b0;
      hold_full <= 1'b0;
      cur_lft   <= '0;
      cur_rght  <= '0;
    end else begin
      underrun <= frame_wrap & ~hold_full;
      if (sclk_fall) begin
        bit_cnt  <= k_next;
        I2S_ws   <= (k_next >= K_SLOT);
        I2S_data <= data_next;
      end
      // An empty hold buffer at the frame boundary repeats the previous pair.
      if (frame_wrap && hold_full) begin
        cur_lft  <= hold_lft;
        cur_rght <= hold_rght;
      end
      if (accept)
        hold_full <= 1'b1;
      else if (frame_wrap)
        hold_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      hold_lft  <= bus.lft_smpl;
      hold_rght <= bus.rght_smpl;
    end
  end

  always_ff @(posedge clk) begin
    assert (!(sclk_fall && sclk_rise));
  end
endmodule

// File: tb/tb_i2s_xmtr.sv
// Bench for i2s_xmtr: cycle-level frame model plus sclk-rise bit capture.
module tb_i2s_xmtr;
  localparam int H          = 2;
  localparam int SLOT       = 24;
  localparam int DW         = 16;
  localparam int FRAME_BITS = 2 * SLOT;
  localparam int FRAME_CLK  = 2 * H * FRAME_BITS;
  localparam int PAD        = SLOT - DW - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic I2S_sclk, I2S_ws, I2S_data, underrun;

  i2s_xmtr_if #(.DATA_W(DW)) bus();

  i2s_xmtr #(.SCLK_HALF(H), .SLOT_BITS(SLOT), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .I2S_sclk (I2S_sclk),
    .I2S_ws   (I2S_ws),
    .I2S_data (I2S_data),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int fails  = 0;
  int nprint = 0;

  // Reference model: clk edges since reset, hold buffer, and the pair owned by each frame.
  int          t;
  bit          m_full;
  bit          m_unr;
  logic [15:0] m_hl, m_hr;
  logic [15:0] fr_l [0:63];
  logic [15:0] fr_r [0:63];
  int          nfr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t      <= 0;
      m_full <= 1'b0;
      m_unr  <= 1'b0;
      fr_l[0] <= '0;
      fr_r[0] <= '0;
      nfr    <= 1;
    end else begin
      t     <= t + 1;
      m_unr <= (((t + 1) % FRAME_CLK) == 0) && !m_full;
      if ((((t + 1) % FRAME_CLK) == 0) && (nfr < 64)) begin
        fr_l[nfr] <= m_full ? m_hl : fr_l[nfr-1];
        fr_r[nfr] <= m_full ? m_hr : fr_r[nfr-1];
        nfr       <= nfr + 1;
      end
      if ((((t + 1) % FRAME_CLK) == 0) && m_full) begin
        m_full <= 1'b0;
      end else if (bus.smpl_vld && !m_full) begin
        m_full <= 1'b1;
        m_hl   <= bus.lft_smpl;
        m_hr   <= bus.rght_smpl;
      end
    end
  end

  // Receiver view: ws/data captured at every sclk rise, plus underrun pulse count.
  logic cap_ws [0:511];
  logic cap_d  [0:511];
  int   ridx;
  int   unr_cnt;
  logic sclk_prev;

  always @(negedge clk) begin
    if (!rst_n) begin
      ridx      <= 0;
      unr_cnt   <= 0;
      sclk_prev <= 1'b0;
    end else begin
      sclk_prev <= I2S_sclk;
      if (I2S_sclk && !sclk_prev && (ridx < 512)) begin
        cap_ws[ridx] <= I2S_ws;
        cap_d[ridx]  <= I2S_data;
        ridx         <= ridx + 1;
      end
      if (underrun) unr_cnt <= unr_cnt + 1;
    end
  end

  function automatic logic exp_bit(input logic [15:0] l, input logic [15:0] r, input int k);
    logic [47:0] fw, sh;
    fw = {1'b0, l, {PAD{1'b0}}, 1'b0, r, {PAD{1'b0}}};
    sh = fw >> (FRAME_BITS - 1 - k);
    return sh[0];
  endfunction

  function automatic logic [23:0] slot_word(input int fr, input int half);
    logic [23:0] s;
    s = '0;
    for (int b = 0; b < SLOT; b++) s = {s[22:0], cap_d[fr * FRAME_BITS + half * SLOT + b]};
    return s;
  endfunction

  function automatic logic [47:0] ws_word(input int fr);
    logic [47:0] s;
    s = '0;
    for (int b = 0; b < FRAME_BITS; b++) s = {s[46:0], cap_ws[fr * FRAME_BITS + b]};
    return s;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_now();
    logic es, ew, ed, er, eu;
    int m, k, f;
    if (!rst_n) begin
      es = 1'b0; ew = 1'b0; ed = 1'b0; er = 1'b1; eu = 1'b0;
    end else begin
      m  = t / (2 * H);
      k  = m % FRAME_BITS;
      f  = m / FRAME_BITS;
      es = ((t / H) % 2) == 1;
      ew = (k >= SLOT);
      ed = (f < nfr) ? exp_bit(fr_l[f], fr_r[f], k) : 1'bx;
      er = !m_full;
      eu = m_unr;
    end
    tests++;
    if ({I2S_sclk, I2S_ws, I2S_data, bus.smpl_rdy, underrun} !== {es, ew, ed, er, eu}) begin
      fails++;
      if (nprint < 20) begin
        nprint++;
        $display("FAIL cycle t=%0d sclk/ws/data/rdy/unr: got %b%b%b%b%b expected %b%b%b%b%b", t,
                 I2S_sclk, I2S_ws, I2S_data, bus.smpl_rdy, underrun, es, ew, ed, er, eu);
      end
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_now();
    end
  endtask

  task automatic run_to(input int target);
    int g;
    g = 0;
    while ((t < target) && (g < 5000)) begin
      tick(1);
      g++;
    end
    if (t < target) chk("run_to_timeout", 64'(t), 64'(target));
  endtask

  task automatic do_reset();
    bus.smpl_vld = 1'b0;
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [15:0] l, input logic [15:0] r);
    bit done;
    done = 1'b0;
    bus.lft_smpl  = l;
    bus.rght_smpl = r;
    bus.smpl_vld  = 1'b1;
    for (int i = 0; i < 400 && !done; i++) begin
      if (bus.smpl_rdy) done = 1'b1;
      tick(1);
    end
    bus.smpl_vld = 1'b0;
    if (!done) chk("send_timeout", 64'(0), 64'(1));
    else chk("rdy_drop_after_accept", 64'(bus.smpl_rdy), 64'(0));
  endtask

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic [23:0] el;
    logic [23:0] er;
  } vec_t;

  vec_t        vecs [3];
  logic [15:0] sent_l [0:7];
  logic [15:0] acc_l, acc_r;
  int          acc_cnt;
  int          rdy_t;
  bit          fire;

  initial begin
    vecs[0] = '{l: 16'hA5C3, r: 16'h1234, el: 24'h52E180, er: 24'h091A00};
    vecs[1] = '{l: 16'h8000, r: 16'h7FFF, el: 24'h400000, er: 24'h3FFF80};
    vecs[2] = '{l: 16'hFFFF, r: 16'h0001, el: 24'h7FFF80, er: 24'h000080};
    bus.lft_smpl  = '0;
    bus.rght_smpl = '0;
    bus.smpl_vld  = 1'b0;

    do_reset();
    chk("reset_sclk", 64'(I2S_sclk), 64'(0));
    chk("reset_rdy", 64'(bus.smpl_rdy), 64'(1));

    // Single pair per reset: zero frame 0, pair in frame 1, repeat with underrun in frame 2.
    for (int v = 0; v < 3; v++) begin
      do_reset();
      tick(10);
      send(vecs[v].l, vecs[v].r);
      run_to(FRAME_CLK + 8);
      chk("unr_none_frame1", 64'(unr_cnt), 64'(0));
      run_to(2 * FRAME_CLK + 8);
      chk("unr_once_frame2", 64'(unr_cnt), 64'(1));
      run_to(3 * FRAME_CLK - 1);
      chk("f0_left_zero", 64'(slot_word(0, 0)), 64'(0));
      chk("f0_right_zero", 64'(slot_word(0, 1)), 64'(0));
      chk("f1_left", 64'(slot_word(1, 0)), 64'(vecs[v].el));
      chk("f1_right", 64'(slot_word(1, 1)), 64'(vecs[v].er));
      chk("f1_ws", 64'(ws_word(1)), 64'(48'h000000FFFFFF));
      chk("f2_left_repeat", 64'(slot_word(2, 0)), 64'(vecs[v].el));
      chk("f2_right_repeat", 64'(slot_word(2, 1)), 64'(vecs[v].er));
    end

    // Back-to-back producer with incrementing pairs.
    do_reset();
    acc_cnt = 0;
    bus.lft_smpl  = 16'h0101;
    bus.rght_smpl = 16'hF0F0;
    bus.smpl_vld  = 1'b1;
    for (int j = 0; j < 5 * FRAME_CLK; j++) begin
      fire = bus.smpl_rdy;
      tick(1);
      if (fire) begin
        if (acc_cnt < 8) sent_l[acc_cnt] = bus.lft_smpl;
        acc_cnt++;
        bus.lft_smpl  = bus.lft_smpl + 16'h0101;
        bus.rght_smpl = bus.rght_smpl - 16'h0011;
      end
    end
    bus.smpl_vld = 1'b0;
    chk("b2b_accepts", 64'(acc_cnt), 64'(5));
    chk("b2b_no_underrun", 64'(unr_cnt), 64'(0));
    chk("b2b_f1_left", 64'(slot_word(1, 0)), 64'({1'b0, sent_l[0], 7'b0}));
    chk("b2b_f3_left", 64'(slot_word(3, 0)), 64'({1'b0, sent_l[2], 7'b0}));

    // Backpressure: data churns every clk while the hold buffer is full.
    do_reset();
    tick(5);
    send(16'h1357, 16'h2468);
    bus.smpl_vld = 1'b1;
    rdy_t = -1;
    for (int i = 0; i < 400 && rdy_t < 0; i++) begin
      bus.lft_smpl  = 16'($urandom);
      bus.rght_smpl = 16'($urandom);
      if (bus.smpl_rdy) begin
        rdy_t = t;
        acc_l = bus.lft_smpl;
        acc_r = bus.rght_smpl;
      end else begin
        tick(1);
      end
    end
    tick(1);
    bus.smpl_vld = 1'b0;
    chk("bp_rdy_rise_time", 64'(rdy_t), 64'(FRAME_CLK));
    run_to(3 * FRAME_CLK - 1);
    chk("bp_f1_left", 64'(slot_word(1, 0)), 64'({1'b0, 16'h1357, 7'b0}));
    chk("bp_f2_left", 64'(slot_word(2, 0)), 64'({1'b0, acc_l, 7'b0}));
    chk("bp_f2_right", 64'(slot_word(2, 1)), 64'({1'b0, acc_r, 7'b0}));

    // Asynchronous reset mid-frame with a pair waiting in the hold buffer.
    do_reset();
    tick(5);
    send(16'hA5C3, 16'h1234);
    run_to(100);
    chk("pre_reset_rdy", 64'(bus.smpl_rdy), 64'(0));
    chk("pre_reset_ws", 64'(I2S_ws), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_sclk", 64'(I2S_sclk), 64'(0));
    chk("midrst_ws", 64'(I2S_ws), 64'(0));
    chk("midrst_data", 64'(I2S_data), 64'(0));
    chk("midrst_rdy", 64'(bus.smpl_rdy), 64'(1));
    tick(2);
    rst_n = 1'b1;
    run_to(2 * FRAME_CLK - 1);
    chk("post_rst_f0_left", 64'(slot_word(0, 0)), 64'(0));
    chk("post_rst_f1_left", 64'(slot_word(1, 0)), 64'(0));
    chk("post_rst_f1_right", 64'(slot_word(1, 1)), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
